// File: rtl/single_max_fp32.sv
// Registered IEEE-754 binary32 maximum with maxNum NaN handling and +0 ranked above -0.
// Define SINGLE_MAX_FTZ_EN to flush subnormal operands to same-signed zero before the compare.
module single_max_fp32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] z
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0] a_f;
    logic [31:0] b_f;
    logic        a_nan;
    logic        b_nan;
    logic [31:0] a_key;
    logic [31:0] b_key;
    logic [31:0] z_d;
    logic [31:0] z_q;

    always_comb begin
        a_f = a;
        b_f = b;
`ifdef SINGLE_MAX_FTZ_EN
        if (a[30:23] == 8'h00) a_f = {a[31], 31'h0};
        if (b[30:23] == 8'h00) b_f = {b[31], 31'h0};
`endif
    end

    assign a_nan = (a_f[30:23] == 8'hFF) && (a_f[22:0] != 23'h0);
    assign b_nan = (b_f[30:23] == 8'hFF) && (b_f[22:0] != 23'h0);

    // Mapping to an unsigned key makes the float total order a plain integer compare.
    assign a_key = a_f[31] ? ~a_f : {1'b1, a_f[30:0]};
    assign b_key = b_f[31] ? ~b_f : {1'b1, b_f[30:0]};

    always_comb begin
        z_d = a_f;
        if (a_nan && b_nan) begin
            z_d = QNAN;
        end else if (a_nan) begin
            z_d = b_f;
        end else if (b_nan) begin
            z_d = a_f;
        end else if (b_key > a_key) begin
            z_d = b_f;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) z_q <= 32'h0;
        else     z_q <= z_d;
    end

    assign z = z_q;

endmodule

// File: tb/tb_single_max_fp32.sv
// Directed and random self-checking bench for single_max_fp32.
// Expected values follow SINGLE_MAX_FTZ_EN when it is defined for the build.
module tb_single_max_fp32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;

    int total;
    int bad;

    single_max_fp32 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sign/magnitude comparison, independent of the RTL key trick.
    function automatic logic [31:0] ref_max(input logic [31:0] x_in, input logic [31:0] y_in);
        logic [31:0] x;
        logic [31:0] y;
        logic        x_nan;
        logic        y_nan;
        x = x_in;
        y = y_in;
`ifdef SINGLE_MAX_FTZ_EN
        if (x[30:23] == 8'h00) x[22:0] = 23'h0;
        if (y[30:23] == 8'h00) y[22:0] = 23'h0;
`endif
        x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        if (x_nan && y_nan) return 32'h7FC00000;
        if (x_nan) return y;
        if (y_nan) return x;
        if (x[31] != y[31]) return x[31] ? y : x;
        if (!x[31]) return (y[30:0] > x[30:0]) ? y : x;
        return (y[30:0] < x[30:0]) ? y : x;
    endfunction

    task automatic test_reset();
        a = 32'h40000000;
        b = 32'h3F800000;
        rst = 1'b1;
        #2;
        total++;
        if (z !== 32'h0) begin
            bad++;
            $display("FAIL reset_init got=%h exp=%h", z, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (z !== 32'h40000000) begin
            bad++;
            $display("FAIL reset_first got=%h exp=%h", z, 32'h40000000);
        end
        a = 32'h3F800000;
        b = 32'h40400000;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (z !== 32'h0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", z, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (z !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", z, 32'h0);
        end
        a = 32'h40000000;
        b = 32'h3F800000;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (z !== 32'h40000000) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", z, 32'h40000000);
        end
    endtask

    task automatic test_ordering();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] ve [10];
        va = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0000000, 32'hFF800000,
               32'h7F800000, 32'h80000000, 32'h00000000, 32'h12345678, 32'hC0000000};
        vb = '{32'h40000000, 32'h3F800000, 32'hC0000000, 32'hBF800000, 32'h7F800000,
               32'hFF800000, 32'h00000000, 32'h80000000, 32'h12345678, 32'h3F800000};
        ve = '{32'h40000000, 32'h40000000, 32'hBF800000, 32'hBF800000, 32'h7F800000,
               32'h7F800000, 32'h00000000, 32'h00000000, 32'h12345678, 32'h3F800000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = va[i];
            b = vb[i];
            @(posedge clk); #1;
            total++;
            if (z !== ve[i]) begin
                bad++;
                $display("FAIL ordering[%0d] a=%h b=%h got=%h exp=%h", i, va[i], vb[i], z, ve[i]);
            end
        end
    endtask

    task automatic test_nan();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] ve [5];
        va = '{32'h7FC00001, 32'h3F800000, 32'h7F800001, 32'hFF800000, 32'hFFFFFFFF};
        vb = '{32'hFF800000, 32'hFF800001, 32'hFFC00000, 32'h7FC12345, 32'h7F800002};
        ve = '{32'hFF800000, 32'h3F800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = va[i];
            b = vb[i];
            @(posedge clk); #1;
            total++;
            if (z !== ve[i]) begin
                bad++;
                $display("FAIL nan[%0d] a=%h b=%h got=%h exp=%h", i, va[i], vb[i], z, ve[i]);
            end
        end
    endtask

    task automatic test_subnormal();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] ve [3];
        va = '{32'h00000001, 32'h80000005, 32'h7FC00000};
        vb = '{32'h80000000, 32'h80000003, 32'h807FFFFF};
`ifdef SINGLE_MAX_FTZ_EN
        ve = '{32'h00000000, 32'h80000000, 32'h80000000};
`else
        ve = '{32'h00000001, 32'h80000003, 32'h807FFFFF};
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = va[i];
            b = vb[i];
            @(posedge clk); #1;
            total++;
            if (z !== ve[i]) begin
                bad++;
                $display("FAIL subnormal[%0d] a=%h b=%h got=%h exp=%h", i, va[i], vb[i], z, ve[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        @(negedge clk);
        a = 32'h41000000;
        b = 32'hC1000000;
        @(posedge clk); #1;
        held = z;
        total++;
        if (held !== 32'h41000000) begin
            bad++;
            $display("FAIL hold_capture got=%h exp=%h", held, 32'h41000000);
        end
        #2;
        a = 32'h7F800000;
        #1;
        total++;
        if (z !== 32'h41000000) begin
            bad++;
            $display("FAIL hold_between_edges got=%h exp=%h", z, 32'h41000000);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[22:0]  = 23'h0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp_z;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            ra = rand_operand();
            rb = ($urandom_range(0, 15) == 0) ? ra : rand_operand();
            if ($urandom_range(0, 15) == 0) rb = ra ^ 32'h80000000;
            a = ra;
            b = rb;
            exp_z = ref_max(ra, rb);
            @(posedge clk); #1;
            total++;
            if (z !== exp_z) begin
                bad++;
                $display("FAIL random[%0d] a=%h b=%h got=%h exp=%h", i, ra, rb, z, exp_z);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        test_reset();
        test_ordering();
        test_nan();
        test_subnormal();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
